// File: rtl/packer_pkg.sv
// Shared definitions for the byte packer.
//
// Contents:
//   default_width_c      default bits per input element
//   default_lanes_c      default elements per packed output word
//   lanes_cnt_width()    width of a count that spans 0..lanes inclusive
package packer_pkg;

    localparam int unsigned default_width_c = 8;
    localparam int unsigned default_lanes_c = 4;

    function automatic int unsigned lanes_cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs lanes_p consecutive width_p-bit elements from a yumi-style upstream
// (fifo producer side) into one wide row word for the systolic-array feeder.
// An accumulator collects lanes 0..lanes_p-2; the final element bypasses the
// accumulator straight into a one-entry output register, so one element per
// cycle is sustained with no bubble at word boundaries. A flush pulse emits
// any partial word, zero-padded, with lanes_valid_o giving the filled count.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous, active-high reset
//   valid_i        upstream element available
//   data_i         upstream element
//   yumi_o         element consumed this cycle
//   flush_i        one-cycle pulse: emit any partial word
//   ready_i        downstream can accept the output word
//   valid_o        output word held
//   data_o         packed word, lane k at [k*width_p +: width_p]
//   lanes_valid_o  number of filled lanes in data_o (1..lanes_p)
module byte_packer
    import packer_pkg::*;
#(
    parameter int unsigned width_p = default_width_c,
    parameter int unsigned lanes_p = default_lanes_c
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 valid_i,
    input  logic [width_p-1:0]                   data_i,
    output logic                                 yumi_o,
    input  logic                                 flush_i,
    input  logic                                 ready_i,
    output logic                                 valid_o,
    output logic [width_p*lanes_p-1:0]           data_o,
    output logic [lanes_cnt_width(lanes_p)-1:0]  lanes_valid_o
);

    localparam int unsigned cnt_w  = lanes_cnt_width(lanes_p);
    localparam int unsigned word_w = width_p * lanes_p;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(lanes_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(lanes_p);

    logic [word_w-1:0] acc_r;
    logic [cnt_w-1:0]  acc_cnt_r;
    logic              flush_pend_r;

    logic out_free;
    logic at_last;
    logic load_full;
    logic load_flush;

    always_comb begin
        out_free   = ~valid_o | ready_i;
        at_last    = (acc_cnt_r == last_cnt);
        // The final element needs the output slot; earlier ones only need
        // the accumulator, which is always free.
        yumi_o     = valid_i & ~reset_i & ~flush_pend_r & (~at_last | out_free);
        load_full  = yumi_o & at_last;
        // yumi_o is held low while a flush is pending, so load_full and
        // load_flush can never fire together.
        load_flush = flush_pend_r & out_free & (acc_cnt_r != '0);
    end

    // Accumulator: lanes 0..lanes_p-2 only; the top lane stays zero so a
    // flushed partial word is already padded.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_r     <= '0;
            acc_cnt_r <= '0;
        end else if (load_flush) begin
            acc_r     <= '0;
            acc_cnt_r <= '0;
        end else if (yumi_o) begin
            if (at_last) begin
                acc_r     <= '0;
                acc_cnt_r <= '0;
            end else begin
                for (int unsigned k = 0; k < lanes_p - 1; k++) begin
                    if (acc_cnt_r == cnt_w'(k)) begin
                        acc_r[k*width_p +: width_p] <= data_i;
                    end
                end
                acc_cnt_r <= acc_cnt_r + 1'b1;
            end
        end
    end

    // A pending flush resolves the first cycle the output slot is free,
    // whether or not there is anything to emit; further flush pulses while
    // pending are absorbed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flush_pend_r <= 1'b0;
        end else if (flush_pend_r) begin
            if (out_free) begin
                flush_pend_r <= 1'b0;
            end
        end else if (flush_i) begin
            flush_pend_r <= 1'b1;
        end
    end

    // One-entry output register; a new word may load in the same edge the
    // previous one transfers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o       <= 1'b0;
            data_o        <= '0;
            lanes_valid_o <= '0;
        end else if (load_full) begin
            valid_o       <= 1'b1;
            data_o        <= {data_i, acc_r[word_w-width_p-1:0]};
            lanes_valid_o <= full_cnt;
        end else if (load_flush) begin
            valid_o       <= 1'b1;
            data_o        <= acc_r;
            lanes_valid_o <= acc_cnt_r;
        end else if (ready_i) begin
            valid_o       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

    localparam int unsigned W = 8;
    localparam int unsigned L = 4;

    logic          clk;
    logic          reset_i;
    logic          valid_i;
    logic [W-1:0]  data_i;
    logic          yumi_o;
    logic          flush_i;
    logic          ready_i;
    logic          valid_o;
    logic [W*L-1:0] data_o;
    logic [2:0]    lanes_valid_o;

    int checks = 0;
    int errors = 0;

    byte_packer #(.width_p(W), .lanes_p(L)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .yumi_o        (yumi_o),
        .flush_i       (flush_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .lanes_valid_o (lanes_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one element, confirm whether it is taken, then clock it.
    task automatic send(input logic [7:0] b, input logic exp_yumi, input string tag);
        valid_i = 1'b1;
        data_i  = b;
        #1;
        check(tag, 64'(yumi_o), 64'(exp_yumi));
        tick();
    endtask

    task automatic check_word(input string tag, input logic v, input logic [31:0] d, input logic [2:0] n);
        check({tag, ".valid"}, 64'(valid_o), 64'(v));
        check({tag, ".data"},  64'(data_o),  64'(d));
        check({tag, ".lanes"}, 64'(lanes_valid_o), 64'(n));
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h99;
        flush_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        #1;
        check("reset_yumi", 64'(yumi_o), 64'd0);
        check_word("reset", 1'b0, 32'h0, 3'd0);
        valid_i = 1'b0;
        reset_i = 1'b0;
        tick();

        // Stream, no backpressure
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b1, "stream_yumi");
            if (i == 4) check_word("stream_w0", 1'b1, 32'h04030201, 3'd4);
            if (i == 5) check("stream_drain", 64'(valid_o), 64'd0);
            if (i == 8) check_word("stream_w1", 1'b1, 32'h08070605, 3'd4);
        end
        valid_i = 1'b0;
        tick();
        check("stream_idle", 64'(valid_o), 64'd0);

        // Backpressure
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, "bp_fill");
        ready_i = 1'b0;
        for (int i = 5; i <= 7; i++) send(8'(i), 1'b1, "bp_accept");
        send(8'h08, 1'b0, "bp_block0");
        send(8'h08, 1'b0, "bp_block1");
        check_word("bp_hold", 1'b1, 32'h04030201, 3'd4);
        ready_i = 1'b1;
        send(8'h08, 1'b1, "bp_release");
        check_word("bp_w1", 1'b1, 32'h08070605, 3'd4);
        valid_i = 1'b0;
        tick();
        check("bp_idle", 64'(valid_o), 64'd0);

        // Partial flush, then normal packing resumes from lane 0
        send(8'hAA, 1'b1, "pf_b0");
        send(8'hBB, 1'b1, "pf_b1");
        valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hCC;
        #1;
        check("pf_pend_yumi", 64'(yumi_o), 64'd0);
        tick();
        check_word("pf_word", 1'b1, 32'h0000BBAA, 3'd2);
        send(8'hCC, 1'b1, "pf_next");
        send(8'hDD, 1'b1, "pf_next");
        send(8'hEE, 1'b1, "pf_next");
        send(8'hFF, 1'b1, "pf_next");
        check_word("pf_after", 1'b1, 32'hFFEEDDCC, 3'd4);
        valid_i = 1'b0;
        tick();

        // Empty flush emits nothing
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        check("ef_none0", 64'(valid_o), 64'd0);
        tick();
        check("ef_none1", 64'(valid_o), 64'd0);

        // Flush coinciding with the final element: one full word only
        send(8'h31, 1'b1, "fc_b");
        send(8'h32, 1'b1, "fc_b");
        send(8'h33, 1'b1, "fc_b");
        flush_i = 1'b1;
        send(8'h34, 1'b1, "fc_last");
        flush_i = 1'b0;
        valid_i = 1'b0;
        check_word("fc_word", 1'b1, 32'h34333231, 3'd4);
        tick();
        check("fc_noextra0", 64'(valid_o), 64'd0);
        tick();
        check("fc_noextra1", 64'(valid_o), 64'd0);

        // Flush together with an accepted element
        send(8'h10, 1'b1, "fb_b0");
        flush_i = 1'b1;
        send(8'h11, 1'b1, "fb_b1");
        flush_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h12;
        #1;
        check("fb_pend_yumi", 64'(yumi_o), 64'd0);
        tick();
        valid_i = 1'b0;
        check_word("fb_word", 1'b1, 32'h00001110, 3'd2);
        tick();
        check("fb_idle", 64'(valid_o), 64'd0);

        // Reset mid-word with a held output word
        ready_i = 1'b0;
        for (int i = 'h41; i <= 'h44; i++) send(8'(i), 1'b1, "rs_fill");
        for (int i = 'h45; i <= 'h47; i++) send(8'(i), 1'b1, "rs_part");
        check_word("rs_held", 1'b1, 32'h44434241, 3'd4);
        valid_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_word("rs_clear", 1'b0, 32'h0, 3'd0);
        ready_i = 1'b1;
        for (int i = 'h21; i <= 'h24; i++) send(8'(i), 1'b1, "rs_next");
        check_word("rs_word", 1'b1, 32'h24232221, 3'd4);
        valid_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
